udma_i2c_reg_if_mc: RTL and testbench

- Parametrised register interface for a uDMA I2C peripheral with NB_CH uDMA channels. Channels are indexed; 0=CMD, 1=RX, 2=TX, and higher indices are extra RX/TX streams.
- Sits between the APB-side cfg bus and the uDMA channel cores / I2C controller.
- Adds to the previous generation:
  - command-stream setup addressed by channel index;
  - timed peripheral reset pulse;
  - saturating arbitration-lost counter;
  - maskable interrupt;
  - lossless sticky status.

---
 rtl/udma_i2c_mc_pkg.sv | 16 +
 rtl/udma_i2c_rst_pulse.sv | 31 +++
 rtl/udma_i2c_reg_if_mc.sv | 125 ++++++++++++
 tb/tb_udma_i2c_reg_if_mc.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/udma_i2c_mc_pkg.sv
// udma_i2c_mc_pkg: register offsets, command opcodes, CFG bit positions and reset FSM states
package udma_i2c_mc_pkg;
  localparam logic [1:0] REG_SADDR  = 2'd0;
  localparam logic [1:0] REG_SIZE   = 2'd1;
  localparam logic [1:0] REG_CFG    = 2'd2;
  localparam logic [1:0] REG_SETUP  = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_IRQ_EN = 2'd2;
  localparam logic [1:0] REG_AL_CNT = 2'd3;
  localparam logic [3:0] OP_UCA = 4'hD;
  localparam logic [3:0] OP_UCS = 4'hE;
  localparam int CFG_CONT_BIT = 0;
  localparam int CFG_EN_BIT   = 4;
  localparam int CFG_CLR_BIT  = 6;
  typedef enum logic {RST_IDLE, RST_PULSE} rst_state_e;
endpackage

// File: rtl/udma_i2c_rst_pulse.sv
// udma_i2c_rst_pulse: fixed-length controller reset pulse, retrigger ignored while active
module udma_i2c_rst_pulse
  import udma_i2c_mc_pkg::*;
#(
  parameter int RST_CYCLES = 8
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic start_i,
  output logic pulse_o
);
  localparam int CW = $clog2(RST_CYCLES + 1);
  rst_state_e     state;
  logic [CW-1:0]  cnt;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state   <= RST_IDLE;
      cnt     <= '0;
      pulse_o <= 1'b0;
    end else if (state == RST_IDLE) begin
      if (start_i) begin
        state   <= RST_PULSE;
        cnt     <= CW'(RST_CYCLES - 1);
        pulse_o <= 1'b1;
      end
    end else if (cnt == '0) begin
      state   <= RST_IDLE;
      pulse_o <= 1'b0;
    end else
      cnt <= cnt - 1'b1;
endmodule

// File: rtl/udma_i2c_reg_if_mc.sv
// udma_i2c_reg_if_mc: multi-channel uDMA I2C register interface with command-stream setup
module udma_i2c_reg_if_mc
  import udma_i2c_mc_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int NB_CH          = 3,
  parameter int RST_CYCLES     = 8,
  parameter int CFG_AW         = 6
) (
  input  logic                                  clk_i,
  input  logic                                  rstn_i,
  input  logic [31:0]                           cfg_data_i,
  input  logic [CFG_AW-1:0]                     cfg_addr_i,
  input  logic                                  cfg_valid_i,
  input  logic                                  cfg_rwn_i,
  output logic [31:0]                           cfg_data_o,
  output logic                                  cfg_ready_o,
  output logic [NB_CH-1:0][L2_AWIDTH_NOAL-1:0]  cfg_startaddr_o,
  output logic [NB_CH-1:0][TRANS_SIZE-1:0]      cfg_size_o,
  output logic [NB_CH-1:0]                      cfg_continuous_o,
  output logic [NB_CH-1:0]                      cfg_en_o,
  output logic [NB_CH-1:0]                      cfg_clr_o,
  input  logic [NB_CH-1:0]                      cfg_en_i,
  input  logic [NB_CH-1:0]                      cfg_pending_i,
  input  logic [NB_CH-1:0][L2_AWIDTH_NOAL-1:0]  cfg_curr_addr_i,
  input  logic [NB_CH-1:0][TRANS_SIZE-1:0]      cfg_bytes_left_i,
  output logic                                  cfg_do_rst_o,
  input  logic                                  status_busy_i,
  input  logic                                  status_al_i,
  output logic                                  irq_o,
  input  logic [31:0]                           udma_cmd_i,
  input  logic                                  udma_cmd_valid_i,
  input  logic                                  udma_cmd_ready_i
);
  logic [CFG_AW-3:0] ch_idx;
  logic [1:0]        off;
  logic              wr, rd, ch_reg, glb, cmd_ok;
  logic [3:0]        cmd_op, cmd_ch;
  logic [NB_CH-1:0]  ch_wr, ch_cmd;
  logic              busy, al, busy_n, al_n;
  logic [1:0]        irq_en, irq_en_n;
  logic [7:0]        al_cnt, al_cnt_n;
  logic              unused_ok;
  assign cfg_ready_o = 1'b1;
  assign ch_idx      = cfg_addr_i[CFG_AW-1:2];
  assign off         = cfg_addr_i[1:0];
  assign wr          = cfg_valid_i & ~cfg_rwn_i;
  assign rd          = cfg_valid_i & cfg_rwn_i;
  assign ch_reg      = ch_idx < (CFG_AW-2)'(NB_CH);
  assign glb         = ch_idx == (CFG_AW-2)'(NB_CH);
  assign cmd_op      = udma_cmd_i[31:28];
  assign cmd_ch      = udma_cmd_i[27:24];
  assign cmd_ok      = udma_cmd_valid_i & udma_cmd_ready_i & (cmd_ch < 4'(NB_CH));
  assign busy_n      = (rd && glb && off == REG_STATUS) ? status_busy_i : busy | status_busy_i;
  assign al_n        = (rd && glb && off == REG_STATUS) ? status_al_i : al | status_al_i;
  assign al_cnt_n    = (rd && glb && off == REG_AL_CNT) ? {7'b0, status_al_i} : al_cnt + 8'(status_al_i && al_cnt != 8'hFF);
  assign irq_en_n    = (wr && glb && off == REG_IRQ_EN) ? cfg_data_i[1:0] : irq_en;
  assign unused_ok   = ^{cfg_data_i, udma_cmd_i};
  always_comb begin
    ch_wr  = '0;
    ch_cmd = '0;
    for (int c = 0; c < NB_CH; c++) begin
      ch_wr[c]  = wr & ch_reg & (ch_idx == (CFG_AW-2)'(c));
      ch_cmd[c] = cmd_ok & (cmd_ch == 4'(c));
    end
  end
  always_comb begin
    cfg_data_o = '0;
    for (int c = 0; c < NB_CH; c++)
      if (ch_reg && ch_idx == (CFG_AW-2)'(c))
        cfg_data_o = off == REG_SADDR ? 32'(cfg_curr_addr_i[c]) :
                     off == REG_SIZE  ? 32'(cfg_bytes_left_i[c]) :
                     off == REG_CFG   ? {26'b0, cfg_pending_i[c], cfg_en_i[c], 3'b0, cfg_continuous_o[c]} : '0;
    if (glb)
      cfg_data_o = off == REG_SETUP  ? {31'b0, cfg_do_rst_o} :
                   off == REG_STATUS ? {30'b0, al, busy} :
                   off == REG_IRQ_EN ? {30'b0, irq_en} : {24'b0, al_cnt};
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      cfg_startaddr_o  <= '0;
      cfg_size_o       <= '0;
      cfg_continuous_o <= '0;
      cfg_en_o         <= '0;
      cfg_clr_o        <= '0;
    end else begin
      cfg_en_o  <= '0;
      cfg_clr_o <= '0;
      for (int c = 0; c < NB_CH; c++) begin
        if (ch_wr[c] && off == REG_SADDR) cfg_startaddr_o[c] <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
        if (ch_wr[c] && off == REG_SIZE) cfg_size_o[c] <= cfg_data_i[TRANS_SIZE-1:0];
        if (ch_wr[c] && off == REG_CFG) begin
          cfg_continuous_o[c] <= cfg_data_i[CFG_CONT_BIT];
          cfg_en_o[c]         <= cfg_data_i[CFG_EN_BIT];
          cfg_clr_o[c]        <= cfg_data_i[CFG_CLR_BIT];
        end
        if (ch_cmd[c] && cmd_op == OP_UCA) cfg_startaddr_o[c] <= udma_cmd_i[L2_AWIDTH_NOAL-1:0];
        if (ch_cmd[c] && cmd_op == OP_UCS) begin
          cfg_size_o[c] <= udma_cmd_i[TRANS_SIZE-1:0];
          cfg_en_o[c]   <= 1'b1;
        end
      end
    end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      busy   <= 1'b0;
      al     <= 1'b0;
      al_cnt <= '0;
      irq_en <= '0;
      irq_o  <= 1'b0;
    end else begin
      busy   <= busy_n;
      al     <= al_n;
      al_cnt <= al_cnt_n;
      irq_en <= irq_en_n;
      irq_o  <= |({al_n, busy_n} & irq_en_n);
    end
  udma_i2c_rst_pulse #(.RST_CYCLES(RST_CYCLES)) u_rst_pulse (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .start_i (wr && glb && off == REG_SETUP && cfg_data_i[0]),
    .pulse_o (cfg_do_rst_o)
  );
endmodule

// File: tb/tb_udma_i2c_reg_if_mc.sv
// tb_udma_i2c_reg_if_mc: directed stimulus checked against a behavioural register-map model
module tb_udma_i2c_reg_if_mc;
  localparam int NB = 3;
  localparam int G = 4 * NB;
  localparam int RST = 8;
  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b1;
  logic [31:0]       cfg_data_i = '0;
  logic [5:0]        cfg_addr_i = '0;
  logic              cfg_valid_i = 1'b0;
  logic              cfg_rwn_i = 1'b0;
  logic [31:0]       cfg_data_o;
  logic              cfg_ready_o;
  logic [NB-1:0][11:0] cfg_startaddr_o;
  logic [NB-1:0][15:0] cfg_size_o;
  logic [NB-1:0]     cfg_continuous_o, cfg_en_o, cfg_clr_o;
  logic [NB-1:0]     cfg_en_i = '0, cfg_pending_i = '0;
  logic [NB-1:0][11:0] cfg_curr_addr_i = '0;
  logic [NB-1:0][15:0] cfg_bytes_left_i = '0;
  logic              cfg_do_rst_o;
  logic              status_busy_i = 1'b0, status_al_i = 1'b0;
  logic              irq_o;
  logic [31:0]       udma_cmd_i = '0;
  logic              udma_cmd_valid_i = 1'b0, udma_cmd_ready_i = 1'b0;
  int checks = 0, errors = 0;
  int m_sa[NB] = '{default: 0};
  int m_sz[NB] = '{default: 0};
  logic [NB-1:0] m_ct = '0, m_en = '0, m_clr = '0;
  logic m_busy = 1'b0, m_al = 1'b0;
  logic [1:0] m_ie = '0;
  int m_alc = 0, m_rst_left = 0;

  udma_i2c_reg_if_mc dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i), .cfg_valid_i(cfg_valid_i), .cfg_rwn_i(cfg_rwn_i),
    .cfg_data_o(cfg_data_o), .cfg_ready_o(cfg_ready_o),
    .cfg_startaddr_o(cfg_startaddr_o), .cfg_size_o(cfg_size_o), .cfg_continuous_o(cfg_continuous_o),
    .cfg_en_o(cfg_en_o), .cfg_clr_o(cfg_clr_o), .cfg_en_i(cfg_en_i), .cfg_pending_i(cfg_pending_i),
    .cfg_curr_addr_i(cfg_curr_addr_i), .cfg_bytes_left_i(cfg_bytes_left_i), .cfg_do_rst_o(cfg_do_rst_o),
    .status_busy_i(status_busy_i), .status_al_i(status_al_i), .irq_o(irq_o),
    .udma_cmd_i(udma_cmd_i), .udma_cmd_valid_i(udma_cmd_valid_i), .udma_cmd_ready_i(udma_cmd_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(int a);
    int c, o;
    c = a / 4;
    o = a % 4;
    if (a < G)
      return o == 0 ? 32'(cfg_curr_addr_i[c]) : o == 1 ? 32'(cfg_bytes_left_i[c]) :
             o == 2 ? 32'(cfg_pending_i[c] * 32 + cfg_en_i[c] * 16 + m_ct[c]) : 32'd0;
    if (a == G) return 32'(m_rst_left > 0);
    if (a == G + 1) return 32'(m_al * 2 + m_busy);
    if (a == G + 2) return 32'(m_ie);
    if (a == G + 3) return 32'(m_alc);
    return 32'd0;
  endfunction

  task automatic model_update();
    int a, c;
    logic w, r;
    a = int'(cfg_addr_i);
    w = cfg_valid_i && !cfg_rwn_i;
    r = cfg_valid_i && cfg_rwn_i;
    m_en = '0;
    m_clr = '0;
    if (w && a < G) begin
      c = a / 4;
      if (a % 4 == 0) m_sa[c] = int'(cfg_data_i % 4096);
      if (a % 4 == 1) m_sz[c] = int'(cfg_data_i % 65536);
      if (a % 4 == 2) begin
        m_ct[c]  = cfg_data_i[0];
        m_en[c]  = cfg_data_i[4];
        m_clr[c] = cfg_data_i[6];
      end
    end
    if (m_rst_left > 0) m_rst_left--;
    else if (w && a == G && cfg_data_i[0]) m_rst_left = RST;
    if (w && a == G + 2) m_ie = cfg_data_i[1:0];
    c = int'(udma_cmd_i[27:24]);
    if (udma_cmd_valid_i && udma_cmd_ready_i && c < NB) begin
      if (udma_cmd_i[31:28] == 4'hD) m_sa[c] = int'(udma_cmd_i % 4096);
      if (udma_cmd_i[31:28] == 4'hE) begin
        m_sz[c] = int'(udma_cmd_i % 65536);
        m_en[c] = 1'b1;
      end
    end
    m_busy = (r && a == G + 1) ? status_busy_i : m_busy | status_busy_i;
    m_al   = (r && a == G + 1) ? status_al_i : m_al | status_al_i;
    if (r && a == G + 3) m_alc = int'(status_al_i);
    else if (status_al_i) m_alc = m_alc < 255 ? m_alc + 1 : 255;
  endtask

  always @(negedge clk_i)
    if (!rstn_i)
      chk("reset_outs", {cfg_en_o, cfg_clr_o, cfg_continuous_o, cfg_do_rst_o, irq_o, cfg_startaddr_o, cfg_size_o}, 32'd0);
    else begin
      chk("en", cfg_en_o, m_en);
      chk("clr", cfg_clr_o, m_clr);
      chk("cont", cfg_continuous_o, m_ct);
      for (int c = 0; c < NB; c++) begin
        chk("saddr", cfg_startaddr_o[c], m_sa[c]);
        chk("size", cfg_size_o[c], m_sz[c]);
      end
      chk("do_rst", cfg_do_rst_o, m_rst_left > 0);
      chk("irq", irq_o, (m_al && m_ie[1]) || (m_busy && m_ie[0]));
      chk("ready", cfg_ready_o, 1);
      if (cfg_valid_i && cfg_rwn_i) chk("rdata", cfg_data_o, exp_rd(int'(cfg_addr_i)));
    end

  task automatic step();
    @(posedge clk_i);
    #1;
    model_update();
  endtask

  task automatic wr(int a, logic [31:0] d);
    cfg_addr_i = 6'(a);
    cfg_data_i = d;
    cfg_rwn_i = 1'b0;
    cfg_valid_i = 1'b1;
    step();
    cfg_valid_i = 1'b0;
  endtask

  task automatic rd(int a, logic [31:0] e, string n);
    cfg_addr_i = 6'(a);
    cfg_rwn_i = 1'b1;
    cfg_valid_i = 1'b1;
    #1;
    chk(n, cfg_data_o, e);
    step();
    cfg_valid_i = 1'b0;
  endtask

  task automatic cmd(logic [31:0] c, logic rdy);
    udma_cmd_i = c;
    udma_cmd_valid_i = 1'b1;
    udma_cmd_ready_i = rdy;
  endtask

  initial begin
    int hi;
    #2 rstn_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    cfg_curr_addr_i = {12'h333, 12'h222, 12'h111};
    cfg_bytes_left_i = {16'h0300, 16'h0200, 16'h0100};
    cfg_en_i = 3'b010;
    rd(G, 0, "setup_reset");
    rd(G + 1, 0, "status_reset");
    rd(G + 2, 0, "irqen_reset");
    rd(G + 3, 0, "alcnt_reset");
    rd(2, 0, "ch0_cfg_reset");
    rd(6, 32'h10, "ch1_cfg_reset");
    rd(4, 32'h222, "ch1_saddr_pass");
    rd(9, 32'h300, "ch2_size_pass");
    rd(3, 0, "reserved_read");
    rd(20, 0, "unmapped_read");
    wr(6, 32'h11);
    chk("ch1_en_pulse", cfg_en_o, 3'b010);
    chk("ch1_cont", cfg_continuous_o, 3'b010);
    step();
    chk("ch1_en_gone", cfg_en_o, 3'b000);
    rd(6, 32'h11, "ch1_cfg_read");
    wr(2, 32'h40);
    chk("ch0_clr_pulse", cfg_clr_o, 3'b001);
    cmd(32'hD2000ABC, 1'b1);
    step();
    chk("uca_ch2", cfg_startaddr_o[2], 12'hABC);
    cmd(32'hE2000040, 1'b1);
    step();
    chk("ucs_ch2_size", cfg_size_o[2], 16'h40);
    chk("ucs_ch2_en", cfg_en_o, 3'b100);
    cmd(32'hE5000010, 1'b1);
    step();
    chk("bad_ch_en", cfg_en_o, 3'b000);
    chk("bad_ch_size", cfg_size_o[2], 16'h40);
    cmd(32'hD1000555, 1'b0);
    step();
    chk("not_ready", cfg_startaddr_o[1], 12'h000);
    cmd(32'hD0000200, 1'b1);
    wr(0, 32'h100);
    chk("collide_saddr", cfg_startaddr_o[0], 12'h200);
    cmd(32'hE2000020, 1'b1);
    wr(6, 32'h10);
    udma_cmd_valid_i = 1'b0;
    chk("collide_en_or", cfg_en_o, 3'b110);
    chk("collide_size", cfg_size_o[2], 16'h20);
    wr(3, 32'hFFFFFFFF);
    wr(20, 32'hFFFFFFFF);
    chk("reserved_wr", cfg_startaddr_o[0], 12'h200);
    wr(G, 1);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      if (cfg_do_rst_o) hi++;
      if (i == 3) wr(G, 1);
      else step();
    end
    chk("rst_len", hi, 8);
    chk("rst_done", cfg_do_rst_o, 0);
    wr(G, 1);
    rd(G, 1, "setup_active");
    repeat (10) step();
    wr(G + 2, 2);
    status_al_i = 1'b1;
    step();
    status_al_i = 1'b0;
    chk("irq_al", irq_o, 1);
    rd(G + 1, 2, "status_al");
    chk("irq_cleared", irq_o, 0);
    rd(G + 3, 1, "alcnt_one");
    status_busy_i = 1'b1;
    step();
    status_busy_i = 1'b0;
    chk("irq_masked", irq_o, 0);
    wr(G + 2, 1);
    chk("irq_busy", irq_o, 1);
    rd(G + 1, 1, "status_busy");
    chk("irq_busy_clr", irq_o, 0);
    status_al_i = 1'b1;
    rd(G + 1, 0, "status_coincide");
    status_al_i = 1'b0;
    rd(G + 1, 2, "status_kept");
    status_al_i = 1'b1;
    repeat (300) step();
    rd(G + 3, 32'hFF, "alcnt_sat");
    status_al_i = 1'b0;
    rd(G + 3, 1, "alcnt_coincide");
    rd(G + 3, 0, "alcnt_cleared");
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
